// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
package ram_arb_pkg;

  localparam int RAM_DEPTH  = 4096;
  localparam int MAX_REQ    = 8;
  localparam int RAM_ADDR_W = $clog2(RAM_DEPTH);
  localparam int RAM_DATA_W = 64;

  typedef logic [RAM_ADDR_W-1:0] addr_t;
  typedef logic [RAM_DATA_W-1:0] data_t;

  // Width of a requester index; never zero so a single requester still has a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Round-robin priority pick: search starts at ptr, first requesting slot wins.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one 1W/1R registered-read RAM between NUM_REQ requesters with independent
// round-robin write and read arbiters. Optional macro RAM_ARB_FWD_EN forwards same-address write data.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      ram_write,
  output logic [ADDR_W-1:0]         ram_wr_addr,
  output logic [DATA_W-1:0]         ram_data_in,
  output logic                      ram_read,
  output logic [ADDR_W-1:0]         ram_rd_addr,
  input  logic [DATA_W-1:0]         ram_data_out
);

  localparam int IW = idx_w(NUM_REQ);

  logic [IW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_id_q, rd_id_d;
  logic               rd_pend_q, rd_pend_d;
  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
  logic [IW-1:0]      wr_idx, rd_idx;
  logic               wr_any, rd_any, wr_go, rd_go, hazard;
  logic [ADDR_W-1:0]  wr_addr_win, rd_addr_win;
  logic [DATA_W-1:0]  wr_data_win;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .req(req_valid & req_write), .ptr(wr_ptr_q), .gnt(wr_gnt), .idx(wr_idx), .any(wr_any)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .req(req_valid & ~req_write), .ptr(rd_ptr_q), .gnt(rd_gnt), .idx(rd_idx), .any(rd_any)
  );

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  assign wr_addr_win = req_addr[int'(wr_idx)*ADDR_W +: ADDR_W];
  assign wr_data_win = req_wdata[int'(wr_idx)*DATA_W +: DATA_W];
  assign rd_addr_win = req_addr[int'(rd_idx)*ADDR_W +: ADDR_W];
  assign hazard      = wr_any && rd_any && (wr_addr_win == rd_addr_win);

  // Nothing is accepted while in reset so no command is silently lost.
  assign wr_go = wr_any && !rst;
`ifdef RAM_ARB_FWD_EN
  assign rd_go = rd_any && !rst;
`else
  assign rd_go = rd_any && !rst && !hazard;
`endif

  assign req_ready   = (wr_go ? wr_gnt : '0) | (rd_go ? rd_gnt : '0);
  assign ram_write   = wr_go;
  assign ram_wr_addr = wr_go ? wr_addr_win : '0;
  assign ram_data_in = wr_go ? wr_data_win : '0;
  assign ram_read    = rd_go;
  assign ram_rd_addr = rd_go ? rd_addr_win : '0;

  always_comb begin
    wr_ptr_d  = wr_go ? next_ptr(wr_idx) : wr_ptr_q;
    rd_ptr_d  = rd_go ? next_ptr(rd_idx) : rd_ptr_q;
    rd_id_d   = rd_go ? rd_idx : rd_id_q;
    rd_pend_d = rd_go;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_id_q   <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_id_q   <= rd_id_d;
      rd_pend_q <= rd_pend_d;
    end
  end

`ifdef RAM_ARB_FWD_EN
  // RAM returns old data on a same-cycle collision, so the written word is captured here instead.
  logic              fwd_hit_q, fwd_hit_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  always_comb begin
    fwd_hit_d  = rd_go && hazard;
    fwd_data_d = fwd_hit_d ? wr_data_win : fwd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
    end
  end
`endif

  // Reset in the response cycle drops the pending read.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (rd_pend_q && !rst) begin
      rsp_valid[rd_id_q] = 1'b1;
`ifdef RAM_ARB_FWD_EN
      rsp_rdata = fwd_hit_q ? fwd_data_q : ram_data_out;
`else
      rsp_rdata = ram_data_out;
`endif
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, shadow memory and a read-response scoreboard.
module tb_ram_port_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = '0, req_write = '0;
  logic [23:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [1:0]   req_ready, rsp_valid;
  logic [63:0]  rsp_rdata, ram_data_in, ram_data_out;
  logic         ram_write, ram_read;
  logic [11:0]  ram_wr_addr, ram_rd_addr;

  int total = 0;
  int bad = 0;
  int wp = 0;
  int rp = 0;

  typedef struct { logic [1:0] vld; logic [63:0] data; } exp_t;
  exp_t exp_q[$];
  logic [63:0] shmem [int];
  logic [63:0] mem [0:4095];

  always #5 clk = ~clk;

  ram_port_arbiter #(.NUM_REQ(2), .ADDR_W(12), .DATA_W(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ram_write(ram_write),
    .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in), .ram_read(ram_read),
    .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out)
  );

  initial for (int i = 0; i < 4096; i++) mem[i] = '0;

  // Registered-read RAM, read-old on collision.
  always @(posedge clk) begin
    if (ram_write) mem[ram_wr_addr] <= ram_data_in;
    if (ram_read) ram_data_out <= mem[ram_rd_addr];
  end

  always @(negedge clk) begin
    if (rsp_valid !== 2'b00) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected got vld=%b data=%h want no response", rsp_valid, rsp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rsp_valid !== e.vld || rsp_rdata !== e.data) begin
          bad++;
          $display("FAIL rsp_data got vld=%b data=%h want vld=%b data=%h", rsp_valid, rsp_rdata, e.vld, e.data);
        end
      end
    end
  end

  function automatic logic [63:0] sh(input int a);
    return shmem.exists(a) ? shmem[a] : 64'h0;
  endfunction

  function automatic logic [1:0] oh(input int i);
    return (i == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic set_req(input int i, input logic v, input logic w, input logic [11:0] a, input logic [63:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_addr[i*12 +: 12] = a;
    req_wdata[i*64 +: 64] = d;
  endtask

  task automatic idle();
    req_valid = '0;
    req_write = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] v, input logic [63:0] d);
    exp_t e;
    e.vld = v;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    idle();
    repeat (3) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_rsp got pending=%0d want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1, 1, 12'h7F0, 64'h11);
    set_req(1, 1, 0, 12'h7F0, 64'h0);
    repeat (2) begin
      @(negedge clk);
      total++; if (ram_write !== 1'b0) begin bad++; $display("FAIL rst_ram_write got=%b want=0", ram_write); end
      total++; if (ram_read !== 1'b0) begin bad++; $display("FAIL rst_ram_read got=%b want=0", ram_read); end
      total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_rsp_valid got=%b want=00", rsp_valid); end
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_req_ready got=%b want=00", req_ready); end
      step();
    end
    rst = 1'b0; wp = 0; rp = 0;
    set_req(1, 1, 1, 12'h7F1, 64'h22);
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_first_grant got=%b want=01", req_ready); end
    shmem[12'h7F0] = 64'h11; wp = 1;
    step();
    set_req(0, 0, 0, 12'h0, 64'h0);
    @(negedge clk);
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rst_second_grant got=%b want=10", req_ready); end
    shmem[12'h7F1] = 64'h22; wp = 0;
    step();
    drain("reset");
  endtask

  task automatic test_write_read();
    set_req(0, 1, 1, 12'h005, 64'hA5A5);
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL wr_ready got=%b want=01", req_ready); end
    total++; if (ram_write !== 1'b1 || ram_wr_addr !== 12'h005 || ram_data_in !== 64'hA5A5) begin
      bad++; $display("FAIL wr_pins got=%b/%h/%h want=1/005/a5a5", ram_write, ram_wr_addr, ram_data_in); end
    shmem[12'h005] = 64'hA5A5; wp = 1;
    step();
    idle();
    set_req(1, 1, 0, 12'h005, 64'h0);
    @(negedge clk);
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rd_ready got=%b want=10", req_ready); end
    total++; if (ram_read !== 1'b1 || ram_rd_addr !== 12'h005 || ram_write !== 1'b0) begin
      bad++; $display("FAIL rd_pins got=%b/%h/%b want=1/005/0", ram_read, ram_rd_addr, ram_write); end
    push_exp(2'b10, sh(12'h005)); rp = 0;
    step();
    idle();
    @(negedge clk);
    total++; if (ram_wr_addr !== 12'h0 || ram_rd_addr !== 12'h0 || ram_data_in !== 64'h0) begin
      bad++; $display("FAIL idle_pins got=%h/%h/%h want=0/0/0", ram_wr_addr, ram_rd_addr, ram_data_in); end
    step();
    drain("write_read");
  endtask

  task automatic test_rr_writes();
    for (int c = 0; c < 6; c++) begin
      set_req(0, 1, 1, 12'h010, 64'h100 + 64'(c));
      set_req(1, 1, 1, 12'h020, 64'h200 + 64'(c));
      @(negedge clk);
      total++; if (req_ready !== oh(wp)) begin bad++; $display("FAIL rr_wr_grant c=%0d got=%b want=%b", c, req_ready, oh(wp)); end
      total++; if (ram_wr_addr !== ((wp == 0) ? 12'h010 : 12'h020)) begin
        bad++; $display("FAIL rr_wr_addr c=%0d got=%h", c, ram_wr_addr); end
      shmem[(wp == 0) ? 12'h010 : 12'h020] = (wp == 0) ? 64'h100 + 64'(c) : 64'h200 + 64'(c);
      wp = 1 - wp;
      step();
    end
    set_req(0, 1, 0, 12'h010, 64'h0);
    set_req(1, 1, 0, 12'h020, 64'h0);
    @(negedge clk);
    total++; if (req_ready !== oh(rp)) begin bad++; $display("FAIL rr_rd_first got=%b want=%b", req_ready, oh(rp)); end
    push_exp(2'b01, sh(12'h010)); rp = 1;
    step();
    set_req(0, 0, 0, 12'h0, 64'h0);
    @(negedge clk);
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rr_rd_held got=%b want=10", req_ready); end
    push_exp(2'b10, sh(12'h020)); rp = 0;
    step();
    drain("rr");
  endtask

  task automatic test_hazard();
    set_req(0, 1, 1, 12'h100, 64'hDEAD);
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL hz_pre got=%b want=01", req_ready); end
    shmem[12'h100] = 64'hDEAD; wp = 1;
    step();
    set_req(0, 1, 1, 12'h100, 64'h1);
    set_req(1, 1, 0, 12'h100, 64'h0);
    @(negedge clk);
`ifdef RAM_ARB_FWD_EN
    total++; if (req_ready !== 2'b11 || ram_read !== 1'b1) begin
      bad++; $display("FAIL hz_fwd got ready=%b read=%b want 11/1", req_ready, ram_read); end
    shmem[12'h100] = 64'h1; wp = 1;
    push_exp(2'b10, 64'h1); rp = 0;
    step();
`else
    total++; if (req_ready !== 2'b01 || ram_read !== 1'b0) begin
      bad++; $display("FAIL hz_stall got ready=%b read=%b want 01/0", req_ready, ram_read); end
    shmem[12'h100] = 64'h1; wp = 1;
    step();
    set_req(0, 0, 0, 12'h0, 64'h0);
    @(negedge clk);
    total++; if (req_ready !== 2'b10 || ram_read !== 1'b1) begin
      bad++; $display("FAIL hz_retry got ready=%b read=%b want 10/1", req_ready, ram_read); end
    push_exp(2'b10, 64'h1); rp = 0;
    step();
`endif
    drain("hazard");
  endtask

  task automatic test_read_write_diff();
    set_req(0, 1, 1, 12'hFFF, 64'hBEEF);
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rw_pre got=%b want=01", req_ready); end
    shmem[12'hFFF] = 64'hBEEF; wp = 1;
    step();
    set_req(0, 1, 0, 12'hFFF, 64'h0);
    set_req(1, 1, 1, 12'h000, 64'h77);
    @(negedge clk);
    total++; if (req_ready !== 2'b11) begin bad++; $display("FAIL rw_both got=%b want=11", req_ready); end
    total++; if (ram_rd_addr !== 12'hFFF || ram_wr_addr !== 12'h000 || ram_data_in !== 64'h77) begin
      bad++; $display("FAIL rw_pins got=%h/%h/%h want=fff/000/77", ram_rd_addr, ram_wr_addr, ram_data_in); end
    push_exp(2'b01, sh(12'hFFF)); rp = 1;
    shmem[12'h000] = 64'h77; wp = 0;
    step();
    drain("read_write");
  endtask

  task automatic test_reset_mid();
    set_req(0, 1, 1, 12'h040, 64'h40);
    set_req(1, 1, 0, 12'h005, 64'h0);
    @(negedge clk);
    total++; if (req_ready !== 2'b11) begin bad++; $display("FAIL rm_grant got=%b want=11", req_ready); end
    shmem[12'h040] = 64'h40;
    step();
    idle();
    rst = 1'b1;
    @(negedge clk);
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rm_dropped got=%b want=00", rsp_valid); end
    step();
    rst = 1'b0; wp = 0; rp = 0;
    set_req(0, 1, 1, 12'h030, 64'h30);
    set_req(1, 1, 1, 12'h031, 64'h31);
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rm_wr_ptr got=%b want=01", req_ready); end
    shmem[12'h030] = 64'h30; wp = 1;
    step();
    set_req(0, 0, 0, 12'h0, 64'h0);
    @(negedge clk);
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rm_wr_next got=%b want=10", req_ready); end
    shmem[12'h031] = 64'h31; wp = 0;
    step();
    set_req(0, 1, 0, 12'h040, 64'h0);
    set_req(1, 1, 0, 12'h031, 64'h0);
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rm_rd_ptr got=%b want=01", req_ready); end
    push_exp(2'b01, sh(12'h040)); rp = 1;
    step();
    set_req(0, 0, 0, 12'h0, 64'h0);
    @(negedge clk);
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rm_rd_next got=%b want=10", req_ready); end
    push_exp(2'b10, sh(12'h031)); rp = 0;
    step();
    drain("reset_mid");
  endtask

  initial begin
    #1;
    test_reset();
    test_write_read();
    test_rr_writes();
    test_hazard();
    test_read_write_diff();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
